// File: rtl/uart_rx_fifo.sv
// UART receiver (5..8 data bits, optional parity) with receive FIFO, sticky error flags and irq.
// Latency: rx->rxs 2 clocks; byte pushed on the stop-sample clock; register reads 1 clock.
// Backpressure: none on the line; a push into a full FIFO is dropped and raises OV.
module uart_rx_fifo #(
   parameter int CLK_HZ     = 27000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   input  logic       sel,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq
);

   localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int HALF  = DIV / 2;
   localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW    = $clog2(DATA_BITS);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
   localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
   // Parity of data+parity bits that counts as correct: 0 for even, 1 for odd.
   localparam logic          PAR_ODD  = (PARITY == 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

   state_t                 state_q, state_d;
   logic                   meta_q, rxs_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   sh_q, sh_d;
   logic                   par_q, par_d;
   logic                   perr_q, perr_d;
   logic                   push, fe_set, pe_set;
   logic [7:0]             push_byte;

   logic [7:0]             mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [AW:0]            fcnt_q;
   logic                   ov_q, fe_q, pe_q, rxie_q, errie_q;
   logic                   rd_en, wr_en, empty, full, pop, push_ok, ov_set, w1c;
   logic                   unused_wdata;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= 1'b1;
         rxs_q  <= 1'b1;
      end else begin
         meta_q <= rx;
         rxs_q  <= meta_q;
      end
   end

   // Receive FSM state and bit-timing registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         perr_q  <= perr_d;
      end
   end

   // Next-state logic: sample mid-bit, accumulate parity, decide push/FE/PE at the stop bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      par_d   = par_q;
      perr_d  = perr_q;
      push    = 1'b0;
      fe_set  = 1'b0;
      pe_set  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs_q) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               par_d   = 1'b0;
               perr_d  = 1'b0;
               state_d = rxs_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == DIV_M1) begin
               cnt_d = '0;
               sh_d  = {rxs_q, sh_q[DATA_BITS-1:1]};
               par_d = par_q ^ rxs_q;
               bit_d = bit_q + 1'b1;
               if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? PAR : STOP;
            end
         end
         PAR: begin
            if (cnt_q == DIV_M1) begin
               cnt_d   = '0;
               perr_d  = (par_q ^ rxs_q) != PAR_ODD;
               state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == DIV_M1) begin
               cnt_d = '0;
               if (rxs_q) begin
                  if (perr_q) pe_set = 1'b1;
                  else        push   = 1'b1;
                  state_d = IDLE;
               end else begin
                  fe_set  = 1'b1;
                  state_d = BRK;
               end
            end
         end
         BRK: begin
            cnt_d = '0;
            if (rxs_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Zero-extend the assembled character to a byte.
   always_comb begin
      push_byte = '0;
      push_byte[DATA_BITS-1:0] = sh_q;
   end

   assign rd_en   = sel & ~we;
   assign wr_en   = sel & we;
   assign empty   = (fcnt_q == '0);
   assign full    = (fcnt_q == FULL_CNT);
   assign pop     = rd_en && (addr == 2'd1) && !empty;
   assign push_ok = push && (!full || pop);
   assign ov_set  = push && full && !pop;
   assign w1c     = wr_en && (addr == 2'd0);
   assign unused_wdata = ^wdata[7:4];

   // FIFO storage; contents need no reset since the count gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= push_byte;
   end

   // Pointers, count, sticky flags (set beats clear), control, read data and irq.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
         ov_q     <= 1'b0;
         fe_q     <= 1'b0;
         pe_q     <= 1'b0;
         rxie_q   <= 1'b0;
         errie_q  <= 1'b0;
         rdata    <= '0;
         irq      <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_ok && !pop)      fcnt_q <= fcnt_q + 1'b1;
         else if (pop && !push_ok) fcnt_q <= fcnt_q - 1'b1;
         ov_q <= ov_set | (ov_q & ~(w1c & wdata[1]));
         fe_q <= fe_set | (fe_q & ~(w1c & wdata[2]));
         pe_q <= pe_set | (pe_q & ~(w1c & wdata[3]));
         if (wr_en && (addr == 2'd2)) begin
            rxie_q  <= wdata[0];
            errie_q <= wdata[1];
         end
         if (rd_en) begin
            case (addr)
               2'd0:    rdata <= {3'b000, full, pe_q, fe_q, ov_q, ~empty};
               2'd1:    rdata <= empty ? 8'h00 : mem[rd_ptr_q];
               2'd2:    rdata <= {6'b0, errie_q, rxie_q};
               default: rdata <= {{(7 - AW){1'b0}}, fcnt_q};
            endcase
         end
         irq <= (rxie_q & ~empty) | (errie_q & (ov_q | fe_q | pe_q));
      end
   end

endmodule
